// File: rtl/alu_operand_loader.sv
// Operand entry front-end for the 4-bit ALU: debounces the load button and steps
// through capturing A, B and the op code from the shared switch bank.
module alu_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       btn_load,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic [2:0] op_out,
  output logic       valid,
  output logic [1:0] step
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StLoadA  = 2'd0,
    StLoadB  = 2'd1,
    StLoadOp = 2'd2,
    StDone   = 2'd3
  } state_e;

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic            db_dly_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press;

  state_e          state_q, state_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            valid_q, valid_d;

  // Button synchronizer, debounce and edge-detect state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_load;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  // Any sample agreeing with the debounced level restarts the stability count.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign press = db_q & ~db_dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLoadA;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      op_q    <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  // Captured operands are kept across DONE -> LOAD_A until overwritten.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    if (press) begin
      unique case (state_q)
        StLoadA: begin
          a_d     = sw;
          state_d = StLoadB;
        end
        StLoadB: begin
          b_d     = sw;
          state_d = StLoadOp;
        end
        StLoadOp: begin
          op_d    = sw[2:0];
          valid_d = 1'b1;
          state_d = StDone;
        end
        StDone: begin
          valid_d = 1'b0;
          state_d = StLoadA;
        end
        default: state_d = StLoadA;
      endcase
    end
  end

  assign a_out  = a_q;
  assign b_out  = b_q;
  assign op_out = op_q;
  assign valid  = valid_q;
  assign step   = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed scenarios plus random button traffic, all
// checked every cycle against a window-based debounce and sequence model.
module tb_alu_operand_loader;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       btn_load;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic [2:0] op_out;
  logic       valid;
  logic [1:0] step;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: raw button samples, debounced level, and the captured operand set.
  bit         hist[$];
  bit         m_db, m_dbq;
  int         m_step;
  logic [3:0] m_a, m_b;
  logic [2:0] m_op;
  bit         m_valid;
  int         step_changes;
  logic [1:0] last_step;

  alu_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .btn_load(btn_load),
    .a_out   (a_out),
    .b_out   (b_out),
    .op_out  (op_out),
    .valid   (valid),
    .step    (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
    m_db    = 1'b0;
    m_dbq   = 1'b0;
    m_step  = 0;
    m_a     = 4'd0;
    m_b     = 4'd0;
    m_op    = 3'd0;
    m_valid = 1'b0;
  endtask

  // Debounced level flips once the synchronized button (two samples late) has
  // disagreed with it for D consecutive edges; a press is its rising edge one cycle on.
  task automatic model_edge();
    bit press;
    bit all_diff;
    press = m_db && !m_dbq;
    if (press) begin
      case (m_step)
        0: m_a = sw;
        1: m_b = sw;
        2: begin m_op = sw[2:0]; m_valid = 1'b1; end
        default: m_valid = 1'b0;
      endcase
      m_step = (m_step + 1) % 4;
    end
    hist.push_back(btn_load);
    if (hist.size() > D + 2) void'(hist.pop_front());
    all_diff = 1'b1;
    for (int i = 0; i < D; i++) if (hist[i] == m_db) all_diff = 1'b0;
    m_dbq = m_db;
    if (all_diff) m_db = !m_db;
  endtask

  task automatic tick();
    logic [1:0] ms;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    ms = m_step[1:0];
    check("cycle", {18'd0, a_out, b_out, op_out, valid, step},
          {18'd0, m_a, m_b, m_op, m_valid, ms});
    check("valid_vs_step", {31'd0, valid}, {31'd0, step == 2'd3});
    if (step != last_step) step_changes++;
    last_step = step;
  endtask

  task automatic press(input logic [3:0] v, input int hi, input int lo);
    sw       = v;
    btn_load = 1'b1;
    repeat (hi) tick();
    btn_load = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    reset        = 1'b1;
    sw           = 4'd0;
    btn_load     = 1'b0;
    step_changes = 0;
    last_step    = 2'd0;
    model_reset();

    // Reset state.
    repeat (2) tick();
    check("reset_zero", {18'd0, a_out, b_out, op_out, valid, step}, 32'd0);
    reset = 1'b0;
    tick();

    // First press latency: capture lands on edge k+6.
    sw       = 4'b1011;
    btn_load = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("a_not_early", {30'd0, step}, 32'd0);
    end
    tick();
    check("a_at_k6", {26'd0, step, a_out}, {26'd0, 2'd1, 4'b1011});
    repeat (13) tick();
    btn_load = 1'b0;
    repeat (10) tick();

    // Full A/B/op sequence, then wrap.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    press(4'h6, 10, 10);
    press(4'h3, 10, 10);
    press(4'h5, 10, 10);
    check("seq_done", {18'd0, a_out, b_out, op_out, valid, step},
          {18'd0, 4'h6, 4'h3, 3'b101, 1'b1, 2'd3});
    press(4'hF, 10, 10);
    check("seq_wrap", {18'd0, a_out, b_out, op_out, valid, step},
          {18'd0, 4'h6, 4'h3, 3'b101, 1'b0, 2'd0});

    // Bounce shorter than the debounce window is ignored.
    step_changes = 0;
    repeat (4) begin
      btn_load = 1'b1;
      tick();
      tick();
      btn_load = 1'b0;
      tick();
    end
    repeat (15) tick();
    check("bounce_step", {30'd0, step}, 32'd0);
    check("bounce_changes", step_changes, 0);

    // Bouncy real press and release yields a single capture.
    sw           = 4'hA;
    step_changes = 0;
    repeat (3) begin
      btn_load = 1'b1;
      tick();
      btn_load = 1'b0;
      tick();
    end
    btn_load = 1'b1;
    repeat (30) tick();
    repeat (3) begin
      btn_load = 1'b0;
      tick();
      btn_load = 1'b1;
      tick();
    end
    btn_load = 1'b0;
    repeat (12) tick();
    check("bouncy_step", {30'd0, step}, 32'd1);
    check("bouncy_a", {28'd0, a_out}, 32'hA);
    check("bouncy_changes", step_changes, 1);

    // Long hold in LOAD_B captures once.
    sw           = 4'h9;
    step_changes = 0;
    btn_load     = 1'b1;
    repeat (100) tick();
    btn_load = 1'b0;
    repeat (12) tick();
    check("hold_step", {30'd0, step}, 32'd2);
    check("hold_b", {28'd0, b_out}, 32'h9);
    check("hold_changes", step_changes, 1);

    // Asynchronous reset mid-debounce while in LOAD_OP.
    btn_load = 1'b1;
    repeat (4) tick();
    #2;
    reset    = 1'b1;
    btn_load = 1'b0;
    model_reset();
    #1;
    check("async_reset", {18'd0, a_out, b_out, op_out, valid, step}, 32'd0);
    tick();
    reset     = 1'b0;
    last_step = step;
    press(4'hC, 10, 10);
    check("post_reset_step", {30'd0, step}, 32'd1);
    check("post_reset_a", {28'd0, a_out}, 32'hC);

    // Random glitches and presses, checked every cycle by the model.
    for (int it = 0; it < 30; it++) begin
      sw = 4'($urandom);
      repeat ($urandom_range(0, 3)) begin
        btn_load = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        btn_load = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      btn_load = 1'b1;
      repeat ($urandom_range(2, 12)) tick();
      btn_load = 1'b0;
      repeat ($urandom_range(2, 12)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream input stage of the 4-bit ALU datapath.
- Sequences operand entry from 4 shared board switches and one raw push-button.
  - Debounces the button.
  - Captures operand A, then operand B, then the operation code.
- Holds all three stable, with a valid flag, for the combinational ALU and shifter stages; b_out[1:0] drives the shift-amount input of the shift stage.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive clk cycles the synchronized button must differ from the debounced level before the debounced level follows it (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
sw  input  4  raw switch bank; shared entry bus for A, B and op
btn_load  input  1  raw, asynchronous, bouncy load button
a_out  output  4  captured operand A
b_out  output  4  captured operand B; [1:0] is the shift amount for the shift stage
op_out  output  3  captured operation select (sw[2:0] at capture)
valid  output  1  high while a_out, b_out and op_out form a complete, stable operand set
step  output  2  current state encoding, drives entry-progress LEDs

Behaviour:
- Reset:
  - Asynchronous, active-high, and may assert at any time, including mid-debounce or mid-entry.
  - Clears: a_out=0, b_out=0, op_out=0, valid=0, step=0 (state LOAD_A), both synchronizer flops=0, debounced level=0, debounce counter=0, edge-detect flop=0.
- Synchronizer: two flops on btn_load (sync1, sync2). sw is sampled directly; the operator holds switches static while pressing.
- Debounce:
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - If sync2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce that returns sync2 to db restarts the count. A pulse shorter than DEBOUNCE_CYCLES synchronized cycles is ignored.
- Press detect:
  - press = db & ~db_q, where db_q is db delayed one cycle.
  - Exactly one press per debounced low-to-high transition. Holding the button gives no repeat. Release gives no event.
- Latency: edge k is the first rising edge that samples btn_load high (stable thereafter).
  - db rises at edge k+1+DEBOUNCE_CYCLES.
  - The FSM acts at edge k+2+DEBOUNCE_CYCLES.
  - Release needs the same debounce time before a new press can be recognized.
- FSM:
  - States: LOAD_A (step=0), LOAD_B (step=1), LOAD_OP (step=2), DONE (step=3).
  - LOAD_A + press: a_out <= sw, go to LOAD_B.
  - LOAD_B + press: b_out <= sw, go to LOAD_OP.
  - LOAD_OP + press: op_out <= sw[2:0], go to DONE, valid <= 1.
  - DONE + press: valid <= 0, go to LOAD_A. a_out, b_out and op_out hold their old values until overwritten.
  - No press: state and all outputs hold.
- All outputs are registered, with no combinational path from sw or btn_load to any output. valid changes on the same edge as the state transition.
- Unused encodings: none (2-bit state, 4 states used).

Test Plan:
- DEBOUNCE_CYCLES=4, reset pulse: all outputs 0, step=0; clean press with sw=4'b1011 held 20 cycles, first sampled at edge k -> a_out=4'b1011 and step=1 after edge k+6, not earlier.
- Full sequence (DEBOUNCE_CYCLES=4):
  - Clean presses with sw=4'h6, then 4'h3, then 4'h5 -> a_out=6, b_out=3, op_out=3'b101.
  - valid rises on the same edge as step=3.
  - A 4th press -> valid=0, step=0, a_out/b_out/op_out still 6/3/5.
- Bounce rejection (DEBOUNCE_CYCLES=4): btn_load toggles high 2 cycles / low 1 cycle for 12 cycles, then stays low -> no state change, step stays 0.
- Bouncy real press: 3 short glitches, then stable high 30 cycles, then bouncy release -> exactly one transition (step 0->1); a_out updated once.
- Hold: button held high 100 cycles in LOAD_B -> exactly one capture; step goes 1->2 only.
- Reset mid-operation: assert reset asynchronously (between edges) while in LOAD_OP with the debounce counter nonzero -> outputs go to 0 immediately without waiting for clk, valid=0, step=0; after release a clean press captures into a_out.
